// File: rtl/dpi_stream_sequencer.sv
// DPI stream sequencer: maps flow keys to 6-bit stream IDs and sequences packets to the regex matchers.
// Optional macro STREAM_STATS_EN adds the pkt_count / drop_count statistics outputs.
module dpi_stream_sequencer #(
    parameter int                   NUM_REGEX      = 8,
    parameter int                   KEY_W          = 16,
    parameter int                   LOAD_GAP       = 2,
    parameter int                   EOP_GAP        = 2,
    parameter logic [NUM_REGEX-1:0] ENABLE_DEFAULT = {NUM_REGEX{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [7:0]           in_data,
    input  logic [KEY_W-1:0]     in_flow_key,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_stream_id,
    input  logic [NUM_REGEX-1:0] cfg_mask,
    output logic                 load_state,
    output logic                 new_stream_id,
    output logic [5:0]           stream_id,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
`ifdef STREAM_STATS_EN
    output logic [NUM_REGEX-1:0] enable,
    output logic [31:0]          pkt_count,
    output logic [15:0]          drop_count
`else
    output logic [NUM_REGEX-1:0] enable
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_LOAD   = 3'd2,
        S_WAIT   = 3'd3,
        S_STREAM = 3'd4,
        S_DRAIN  = 3'd5
    } state_e;

    // Outputs are registered, so the last WAIT/DRAIN cycle sits one cycle ahead of the visible gap.
    localparam logic [7:0] WAIT_LAST = 8'(LOAD_GAP - 2);
    localparam logic [7:0] EOP_LAST  = 8'(EOP_GAP - 1);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [KEY_W-1:0]       key_q;
    logic [5:0]             sid_q;
    logic                   new_q;
    logic [5:0]             alloc_ptr_q;

    logic [63:0]            tbl_vld_q;
    logic [KEY_W-1:0]       tbl_key_q  [64];
    logic [NUM_REGEX-1:0]   tbl_mask_q [64];

    logic                   hit_s;
    logic [5:0]             hit_idx_s;
    logic                   in_ready_s;
    logic                   capture_s;
    logic                   lookup_s;
    logic                   alloc_s;
    logic                   load_s;
    logic                   accept_s;
    logic                   drop_s;
    logic                   eop_s;

    logic                   load_state_q;
    logic                   new_stream_id_q;
    logic [5:0]             stream_id_q;
    logic [7:0]             char_in_q;
    logic                   char_in_vld_q;
    logic                   eop_q;
    logic [NUM_REGEX-1:0]   enable_q;

    // Parallel key compare; scanning downward leaves the lowest matching index.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            hit_s     = hit_s | (tbl_vld_q[i] & (tbl_key_q[i] == key_q));
            hit_idx_s = (tbl_vld_q[i] && (tbl_key_q[i] == key_q)) ? 6'(i) : hit_idx_s;
        end
    end

    // FSM next-state and per-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_s = 1'b0;
        capture_s  = 1'b0;
        lookup_s   = 1'b0;
        load_s     = 1'b0;
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        eop_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_s = ~(in_vld & in_sop);
                if (in_vld && in_sop) begin
                    capture_s = 1'b1;
                    state_d   = S_LOOKUP;
                end else begin
                    drop_s = in_vld;
                end
            end
            S_LOOKUP: begin
                lookup_s = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                load_s  = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STREAM: begin
                in_ready_s = 1'b1;
                accept_s   = in_vld;
                if (in_vld && in_eop) begin
                    cnt_d   = 8'd0;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (cnt_q == EOP_LAST) begin
                    eop_s   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign alloc_s  = lookup_s & ~hit_s;
    assign in_ready = in_ready_s;

    // FSM state and gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Packet context: captured key, resolved stream and allocation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= {KEY_W{1'b0}};
            sid_q       <= 6'd0;
            new_q       <= 1'b0;
            alloc_ptr_q <= 6'd0;
        end else begin
            if (capture_s) begin
                key_q <= in_flow_key;
            end
            if (lookup_s) begin
                sid_q <= hit_s ? hit_idx_s : alloc_ptr_q;
                new_q <= ~hit_s;
            end
            if (alloc_s) begin
                alloc_ptr_q <= alloc_ptr_q + 6'd1;
            end
        end
    end

    // Flow table; a miss allocation overrides a same-cycle mask write to that entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld_q <= 64'd0;
            for (int i = 0; i < 64; i++) begin
                tbl_key_q[i]  <= {KEY_W{1'b0}};
                tbl_mask_q[i] <= {NUM_REGEX{1'b0}};
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (alloc_s && (alloc_ptr_q == 6'(i))) begin
                    tbl_vld_q[i]  <= 1'b1;
                    tbl_key_q[i]  <= key_q;
                    tbl_mask_q[i] <= ENABLE_DEFAULT;
                end else if (cfg_we && (cfg_stream_id == 6'(i))) begin
                    tbl_mask_q[i] <= cfg_mask;
                end
            end
        end
    end

    // Matcher-side outputs; stream_id/enable only change on LOAD so they hold through eop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_state_q    <= 1'b0;
            new_stream_id_q <= 1'b0;
            stream_id_q     <= 6'd0;
            enable_q        <= {NUM_REGEX{1'b0}};
            char_in_q       <= 8'd0;
            char_in_vld_q   <= 1'b0;
            eop_q           <= 1'b0;
        end else begin
            load_state_q    <= load_s;
            new_stream_id_q <= load_s & new_q;
            char_in_vld_q   <= accept_s;
            eop_q           <= eop_s;
            if (load_s) begin
                stream_id_q <= sid_q;
                enable_q    <= tbl_mask_q[sid_q];
            end
            if (accept_s) begin
                char_in_q <= in_data;
            end
        end
    end

    assign load_state    = load_state_q;
    assign new_stream_id = new_stream_id_q;
    assign stream_id     = stream_id_q;
    assign enable        = enable_q;
    assign char_in       = char_in_q;
    assign char_in_vld   = char_in_vld_q;
    assign eop           = eop_q;

`ifdef STREAM_STATS_EN
    logic [31:0] pkt_count_q;
    logic [15:0] drop_count_q;

    // Statistics: wrapping packet count, saturating discard count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q  <= 32'd0;
            drop_count_q <= 16'd0;
        end else begin
            if (eop_s) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
            if (drop_s && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Self-checking bench for dpi_stream_sequencer: random packets against a flow-table reference model.
module tb_dpi_stream_sequencer;

    localparam int LOAD_GAP = 2;
    localparam int EOP_GAP  = 2;

    logic        clk;
    logic        rst_n;
    logic        in_vld, in_ready, in_sop, in_eop;
    logic [7:0]  in_data;
    logic [15:0] in_flow_key;
    logic        cfg_we;
    logic [5:0]  cfg_stream_id;
    logic [7:0]  cfg_mask;
    logic        load_state, new_stream_id, char_in_vld, eop;
    logic [5:0]  stream_id;
    logic [7:0]  char_in;
    logic [7:0]  enable;
`ifdef STREAM_STATS_EN
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
`endif

    dpi_stream_sequencer #(
        .NUM_REGEX(8), .KEY_W(16), .LOAD_GAP(LOAD_GAP), .EOP_GAP(EOP_GAP), .ENABLE_DEFAULT(8'hFF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_flow_key(in_flow_key),
        .cfg_we(cfg_we), .cfg_stream_id(cfg_stream_id), .cfg_mask(cfg_mask),
        .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
        .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
`ifdef STREAM_STATS_EN
        .enable(enable), .pkt_count(pkt_count), .drop_count(drop_count)
`else
        .enable(enable)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    typedef struct { int cyc; logic [5:0] sid; logic nw; logic [7:0] en; } ls_rec_t;
    typedef struct { int cyc; logic [7:0] d; } ch_rec_t;
    ls_rec_t ls_q[$];
    ch_rec_t ch_q[$];
    int      eop_q[$];
    int      unstable_cnt = 0;
    logic    mon_active = 1'b0;
    logic [5:0] mon_sid = 6'd0;
    logic [7:0] mon_en  = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active <= 1'b0;
        end else begin
            if (load_state) begin
                ls_q.push_back('{cyc, stream_id, new_stream_id, enable});
                mon_active <= 1'b1;
                mon_sid    <= stream_id;
                mon_en     <= enable;
            end
            if (char_in_vld) ch_q.push_back('{cyc, char_in});
            if (mon_active && ((stream_id != mon_sid) || (enable != mon_en)))
                unstable_cnt <= unstable_cnt + 1;
            if (eop) begin
                eop_q.push_back(cyc);
                mon_active <= 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] m_key  [64];
    bit          m_vld  [64];
    logic [7:0]  m_mask [64];
    int          m_ptr;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic model_pkt(input logic [15:0] key, output int sid, output bit nw, output logic [7:0] en);
        sid = -1;
        for (int i = 0; i < 64; i++) if (sid < 0 && m_vld[i] && m_key[i] == key) sid = i;
        nw = (sid < 0);
        if (nw) begin
            sid = m_ptr;
            m_vld[sid]  = 1'b1;
            m_key[sid]  = key;
            m_mask[sid] = 8'hFF;
            m_ptr = (m_ptr + 1) % 64;
        end
        en = m_mask[sid];
    endtask

    // ---------------- drivers (entered and left at posedge+1) ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop_f);
        int n = 0;
        bit took = 1'b0;
        in_vld = 1'b1; in_data = d; in_sop = sop; in_eop = eop_f;
        while (!took && n < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        if (!took) check_eq("beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic cfg_write(input logic [5:0] sid, input logic [7:0] mask);
        cfg_we = 1'b1; cfg_stream_id = sid; cfg_mask = mask;
        step(1);
        cfg_we = 1'b0;
        m_mask[sid] = mask;
    endtask

    task automatic do_reset();
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_we = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 64'd1);
        check_eq("rst_outputs", {load_state, new_stream_id, char_in_vld, eop, stream_id, char_in, enable}, 64'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        step(1);
    endtask

    // One packet: random payload, optional gaps / stray sop / mid-packet cfg write to the active stream.
    task automatic run_packet(input logic [15:0] key, input int len, input bit gaps,
                              output logic [5:0] got_sid, output logic got_new);
        int ls0 = ls_q.size();
        int ch0 = ch_q.size();
        int ep0 = eop_q.size();
        int us0 = unstable_cnt;
        int exp_sid, n;
        bit exp_new;
        logic [7:0] exp_en;
        logic [7:0] bytes[$];
        model_pkt(key, exp_sid, exp_new, exp_en);
        for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
        in_flow_key = key;
        for (int i = 0; i < len; i++) begin
            if (gaps && i == 1 && $urandom_range(0, 1) == 1) cfg_write(6'(exp_sid), 8'($urandom));
            if (gaps && i > 0) step($urandom_range(0, 2));
            send_beat(bytes[i], (i == 0) || (gaps && $urandom_range(0, 5) == 0), i == len - 1);
        end
        n = 0;
        while (eop_q.size() == ep0 && n < 40) begin step(1); n++; end
        step(3);
        got_sid = 6'd0; got_new = 1'b0;
        check_eq("load_count", ls_q.size() - ls0, 64'd1);
        check_eq("char_count", ch_q.size() - ch0, len);
        check_eq("eop_count", eop_q.size() - ep0, 64'd1);
        check_eq("id_enable_stable", unstable_cnt - us0, 64'd0);
        if (ls_q.size() > ls0) begin
            got_sid = ls_q[ls0].sid;
            got_new = ls_q[ls0].nw;
            check_eq("stream_id", ls_q[ls0].sid, exp_sid);
            check_eq("new_stream_id", ls_q[ls0].nw, exp_new);
            check_eq("enable", ls_q[ls0].en, exp_en);
            if (ch_q.size() > ch0) check_eq("load_gap", ch_q[ch0].cyc - ls_q[ls0].cyc, LOAD_GAP);
        end
        for (int i = 0; i < len && ch0 + i < ch_q.size(); i++) check_eq("char_in", ch_q[ch0 + i].d, bytes[i]);
        if (ch_q.size() == ch0 + len && eop_q.size() > ep0) begin
            check_eq("eop_gap", eop_q[ep0] - ch_q[ch0 + len - 1].cyc, EOP_GAP);
            if (!gaps) check_eq("char_contig", ch_q[ch0 + len - 1].cyc - ch_q[ch0].cyc, len - 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] s;
        logic       nw;
        int         chb, lsb, epb;
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'd0; in_flow_key = 16'd0;
        cfg_we = 1'b0; cfg_stream_id = 6'd0; cfg_mask = 8'd0; rst_n = 1'b0;
        model_reset();
        do_reset();

        run_packet(16'h1234, 4, 1'b0, s, nw);
        check_eq("first_alloc", {nw, s}, {1'b1, 6'd0});
        run_packet(16'h1234, 3, 1'b0, s, nw);
        check_eq("same_key_hit", {nw, s}, {1'b0, 6'd0});
        run_packet(16'hABCD, 2, 1'b0, s, nw);
        check_eq("second_alloc", {nw, s}, {1'b1, 6'd1});
        cfg_write(6'd0, 8'h05);
        run_packet(16'h1234, 4, 1'b0, s, nw);
        run_packet(16'h1234, 1, 1'b0, s, nw);
        run_packet(16'hABCD, 6, 1'b1, s, nw);

        // Stray non-sop beats in IDLE are discarded.
        do_reset();
        chb = ch_q.size(); lsb = ls_q.size();
        for (int i = 0; i < 3; i++) send_beat(8'hA0 + 8'(i), 1'b0, 1'b0);
        step(6);
        check_eq("stray_chars", ch_q.size() - chb, 64'd0);
        check_eq("stray_loads", ls_q.size() - lsb, 64'd0);
`ifdef STREAM_STATS_EN
        check_eq("drop_count", drop_count, 64'd3);
`endif

        // 65 distinct keys wrap the allocator; the first key is then evicted and re-allocated.
        for (int i = 0; i < 65; i++) run_packet(16'h1000 + 16'(i), $urandom_range(1, 3), 1'b0, s, nw);
        check_eq("wrap_alloc", {nw, s}, {1'b1, 6'd0});
        run_packet(16'h1000, 2, 1'b0, s, nw);
        check_eq("evicted_realloc", {nw, s}, {1'b1, 6'd1});
`ifdef STREAM_STATS_EN
        check_eq("pkt_count", pkt_count, 64'd66);
`endif

        // Random traffic over a small key pool with cfg writes between packets.
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 3) == 0) cfg_write(6'($urandom_range(0, 63)), 8'($urandom));
            if ($urandom_range(0, 4) == 0) step($urandom_range(1, 3));
            run_packet(16'h2000 + 16'($urandom_range(0, 7)), $urandom_range(1, 6), 1'($urandom_range(0, 1)), s, nw);
        end

        // Reset in the middle of STREAM: immediate abort, no eop, remainder discarded.
        in_flow_key = 16'h5555;
        send_beat(8'h11, 1'b1, 1'b0);
        send_beat(8'h22, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_outputs", {load_state, new_stream_id, char_in_vld, eop, stream_id, char_in, enable}, 64'd0);
        check_eq("abort_in_ready", in_ready, 64'd1);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        step(1);
        chb = ch_q.size(); epb = eop_q.size();
        send_beat(8'h33, 1'b0, 1'b0);
        send_beat(8'h44, 1'b0, 1'b1);
        step(10);
        check_eq("abort_no_eop", eop_q.size() - epb, 64'd0);
        check_eq("abort_no_chars", ch_q.size() - chb, 64'd0);
`ifdef STREAM_STATS_EN
        check_eq("abort_drop_count", drop_count, 64'd2);
`endif
        run_packet(16'h5555, 3, 1'b0, s, nw);
        check_eq("post_abort_alloc", {nw, s}, {1'b1, 6'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dpi_stream_sequencer.md
Name: dpi_stream_sequencer

Overview:
Front end of each DPI regex matcher bank. Accepts raw packet bytes tagged with a flow key, maps each key to a 6-bit stream ID through a 64-entry flow table, and drives the matcher-side interface. Per packet this is a load_state/new_stream_id pulse, the char_in/char_in_vld byte stream, a trailing eop pulse and the per-stream enable mask. It is the producer end of the stream_id/load_state/eop protocol consumed by the per-regex counting wrappers.

Parameters:
NUM_REGEX, 8, width of the per-stream enable mask (one bit per regex matcher)
KEY_W, 16, flow key width
LOAD_GAP, 2, cycles from load_state pulse to first char_in_vld (min 2)
EOP_GAP, 2, cycles from last char_in_vld to eop pulse (min 1)
ENABLE_DEFAULT, {NUM_REGEX{1'b1}}, mask written on flow allocation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_vld  in  1  input byte valid
in_ready  out  1  input byte accepted when in_vld & in_ready
in_sop  in  1  first byte of packet
in_eop  in  1  last byte of packet
in_data  in  8  packet byte
in_flow_key  in  KEY_W  flow key, valid with in_sop
cfg_we  in  1  write enable-mask entry
cfg_stream_id  in  6  entry to write
cfg_mask  in  NUM_REGEX  mask value
load_state  out  1  1-cycle pulse: matchers restore/clear state
new_stream_id  out  1  qualifies load_state: flow newly allocated
stream_id  out  6  current stream, held from load_state through eop
char_in  out  8  byte to matchers
char_in_vld  out  1  char_in valid
eop  out  1  1-cycle end-of-packet pulse
enable  out  NUM_REGEX  per-regex enable for current stream, held like stream_id

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low. Reset clears all table valid bits, alloc_ptr=0 and FSM=IDLE. All outputs go to 0, except in_ready which is 1 in IDLE.
- Flow table: 64 entries, each {valid, key[KEY_W], mask[NUM_REGEX]}. Lookup is a full parallel compare.
- FSM states and transitions:
  - IDLE: in_ready=1.
    - Beat with in_vld & ~in_sop: consumed and discarded.
    - Beat with in_vld & in_sop: not consumed (in_ready drops to 0 combinationally). Key is registered. Go to LOOKUP.
  - LOOKUP: 1 cycle.
    - Hit: sid=matching index (lowest index if several), new=0.
    - Miss: sid=alloc_ptr, new=1. Entry written {1, key, ENABLE_DEFAULT}. alloc_ptr increments mod 64. A valid entry is silently evicted.
  - LOAD: 1 cycle. load_state=1, new_stream_id=new. stream_id and enable are registered from the table; enable reflects any cfg write completed before this cycle. Go to WAIT.
  - WAIT: LOAD_GAP-1 cycles, in_ready=0. Go to STREAM.
  - STREAM: in_ready=1. char_in=in_data and char_in_vld=1 in the cycle after each accepted beat (1-cycle registered latency).
    - in_sop on a non-first beat is ignored.
    - Accepted beat with in_eop: go to DRAIN; in_ready=0 from the next cycle.
  - DRAIN: eop asserted for exactly 1 cycle, EOP_GAP cycles after the last char_in_vld. Then go to IDLE.
- The sop beat is the first char streamed; a 1-byte packet (sop & eop) is legal.
- stream_id and enable stay stable from LOAD through the eop cycle. char_in_vld is 0 outside STREAM.
- cfg_we may occur in any state and updates only the mask. A write to the active stream takes effect at that stream's next LOAD. A cfg write and a miss-allocation to the same entry in the same cycle: allocation wins.
- Reset mid-packet: immediate abort. No eop is emitted. The remainder of the packet is discarded in IDLE as non-sop beats.

Optional Feature:
STREAM_STATS_EN
- Defined: adds outputs pkt_count[31:0] and drop_count[15:0].
  - pkt_count: +1 per eop pulse, wraps.
  - drop_count: +1 per beat discarded in IDLE, saturates at 16'hFFFF.
  - Both are cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then 4-byte packet key 16'h1234 -> load_state with new_stream_id=1, stream_id=0, enable=8'hFF. chars appear 2 cycles later on consecutive cycles. eop 2 cycles after last char.
- Second packet, same key 16'h1234 -> new_stream_id=0, stream_id=0. Third packet, key 16'hABCD -> new_stream_id=1, stream_id=1.
- cfg_we with stream 0, mask 8'h05, then a key 16'h1234 packet -> enable=8'h05 from load_state through eop.
- 65 distinct keys -> 65th gets stream_id=0, new_stream_id=1. A subsequent packet with the 1st key misses and is allocated stream_id=1.
- 1-byte packet (sop&eop), in_vld gapped mid-packet, and 3 stray non-sop beats in IDLE -> single char_in_vld, eop still EOP_GAP after last char, stray beats never appear on char_in. With STREAM_STATS_EN: drop_count=3.
- rst_n asserted in the middle of STREAM -> outputs 0 asynchronously, no eop. Next packet with the same key reports new_stream_id=1, stream_id=0.
